// File: rtl/fir_pkg.sv
// Shared constants, FSM state type and output saturation for the sequential high-pass FIR.
package fir_pkg;

  localparam int DATA_W = 16;                        // sample / output width, Q1.15
  localparam int COEF_W = 16;                        // coefficient width, Q1.15
  localparam int ADDR_W = 5;                         // coefficient / delay-line address width
  localparam int TAPS   = 2 ** ADDR_W;               // filter length
  localparam int PROD_W = DATA_W + COEF_W;           // full-precision product width
  localparam int ACC_W  = DATA_W + COEF_W + ADDR_W;  // sum of TAPS products cannot overflow
  localparam int SHIFT  = 15;                        // Q2.30 product back to Q1.15

  // Half an output LSB, added before the arithmetic shift for round-half-up.
  localparam logic signed [ACC_W-1:0] ROUND_K = ACC_W'(2 ** (SHIFT - 1));

  // Output clamp limits expressed at accumulator width.
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2 ** (DATA_W - 1) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_OUT
  } state_t;

  // Clamp a rounded, shifted accumulator value into the signed 16-bit output range.
  function automatic logic signed [DATA_W-1:0] sat16(input logic signed [ACC_W-1:0] v);
    logic signed [DATA_W-1:0] r;
    if (v > SAT_MAX) begin
      r = SAT_MAX[DATA_W-1:0];
    end else if (v < SAT_MIN) begin
      r = SAT_MIN[DATA_W-1:0];
    end else begin
      r = v[DATA_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_delay_line.sv
// 32-entry sample history: one synchronous write port, one asynchronous read port,
// every entry cleared by reset so the filter always starts from a zero history.
module fir_delay_line
  import fir_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [TAPS];

  // Sample write with asynchronous clear of the entire history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: every entry is reset, not only the pointers: stale samples from before a
      // reset would otherwise leak into the first 31 outputs afterwards.
      for (int i = 0; i < TAPS; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fir_hp_coef_rom.sv
// High-pass coefficient table, Q1.15, antisymmetric (h[k] = -h[31-k]), combinational read.
// Lives beside the FIR controller and is addressed by its coef_addr output.
module fir_hp_coef_rom
  import fir_pkg::*;
(
  input  logic        [ADDR_W-1:0] addr,
  output logic signed [COEF_W-1:0] data
);

  // Combinational table lookup.
  always_comb begin
    data = '0;
    case (addr)
      5'd0:  data = -16'sd32;
      5'd1:  data = -16'sd45;
      5'd2:  data = -16'sd60;
      5'd3:  data = -16'sd88;
      5'd4:  data = -16'sd120;
      5'd5:  data = -16'sd170;
      5'd6:  data = -16'sd240;
      5'd7:  data = -16'sd330;
      5'd8:  data = -16'sd460;
      5'd9:  data = -16'sd650;
      5'd10: data = -16'sd930;
      5'd11: data = -16'sd1350;
      5'd12: data = -16'sd2050;
      5'd13: data = -16'sd3400;
      5'd14: data = -16'sd7000;
      5'd15: data =  16'sd20633;
      5'd16: data = -16'sd20633;
      5'd17: data =  16'sd7000;
      5'd18: data =  16'sd3400;
      5'd19: data =  16'sd2050;
      5'd20: data =  16'sd1350;
      5'd21: data =  16'sd930;
      5'd22: data =  16'sd650;
      5'd23: data =  16'sd460;
      5'd24: data =  16'sd330;
      5'd25: data =  16'sd240;
      5'd26: data =  16'sd170;
      5'd27: data =  16'sd120;
      5'd28: data =  16'sd88;
      5'd29: data =  16'sd60;
      5'd30: data =  16'sd45;
      5'd31: data =  16'sd32;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/fir_hp_mac_seq.sv
// Time-multiplexed 32-tap FIR controller: accepts one sample, walks all taps through a
// single multiplier into one accumulator, then emits a rounded, saturated 16-bit result.
module fir_hp_mac_seq
  import fir_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [DATA_W-1:0] din,
  input  logic                     din_valid,
  output logic                     din_ready,
  output logic        [ADDR_W-1:0] coef_addr,
  input  logic signed [COEF_W-1:0] coef,
  output logic signed [DATA_W-1:0] dout,
  output logic                     dout_valid,
  output logic                     busy
);

  state_t                    state_q;
  state_t                    state_d;
  logic        [ADDR_W-1:0]  k_q;       // tap index, 0 = newest sample
  logic        [ADDR_W-1:0]  wr_ptr_q;  // next delay-line slot to write
  logic        [ADDR_W-1:0]  base_q;    // slot holding the newest sample
  logic        [ADDR_W-1:0]  tap_addr;
  logic        [DATA_W-1:0]  tap_raw;
  logic signed [DATA_W-1:0]  tap;
  logic signed [PROD_W-1:0]  prod;
  logic signed [ACC_W-1:0]   acc_q;
  logic signed [ACC_W-1:0]   acc_rnd;
  logic                      accept;
  logic                      last_tap;

  assign accept   = din_valid && din_ready;
  assign last_tap = (k_q == ADDR_W'(TAPS - 1));

  // Walking backwards from the newest sample; the 5-bit subtraction wraps modulo 32.
  assign tap_addr = base_q - k_q;

  fir_delay_line u_line (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (accept),
    .waddr (wr_ptr_q),
    .wdata (din),
    .raddr (tap_addr),
    .rdata (tap_raw)
  );

  assign tap     = signed'(tap_raw);
  assign prod    = tap * coef;
  assign acc_rnd = (acc_q + ROUND_K) >>> SHIFT;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples the
      // pre-edge values, independent of the order of statements or blocks.
      state_q <= state_d;
    end
  end

  // Next-state logic and handshake / ROM address outputs.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    state_d   = state_q;
    din_ready = 1'b0;
    busy      = 1'b0;
    coef_addr = '0;
    unique case (state_q)
      S_IDLE: begin
        din_ready = 1'b1;
        if (din_valid) begin
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        busy      = 1'b1;
        coef_addr = k_q;
        if (last_tap) begin
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        busy    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Pointers, tap counter, multiply-accumulate and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      base_q     <= '0;
      k_q        <= '0;
      acc_q      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            base_q   <= wr_ptr_q;
            wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
            k_q      <= '0;
            acc_q    <= '0;
          end
        end
        S_MAC: begin
          acc_q <= acc_q + ACC_W'(prod);
          k_q   <= k_q + ADDR_W'(1);
        end
        S_OUT: begin
          dout       <= sat16(acc_rnd);
          dout_valid <= 1'b1;
        end
        default: begin
          k_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_hp_mac_seq.sv
// Self-checking bench for fir_hp_mac_seq with the coefficient ROM beside it.
// Expected outputs come from an integer convolution over a bench-side history and are
// queued at acceptance, then popped when dout_valid is seen.
module tb_fir_hp_mac_seq;

  logic               clk = 1'b0;
  logic               rst_n;
  logic signed [15:0] din;
  logic               din_valid;
  logic               din_ready;
  logic        [4:0]  coef_addr;
  logic signed [15:0] coef;
  logic signed [15:0] dout;
  logic               dout_valid;
  logic               busy;

  int checks   = 0;
  int failures = 0;

  logic [15:0] exp_q [$];
  logic [15:0] obs_q [$];
  int          tb_line [32];
  int          tb_wr;
  int          h [32] = '{  -32,    -45,   -60,   -88,  -120,  -170,  -240,  -330,
                            -460,  -650,  -930, -1350, -2050, -3400, -7000, 20633,
                          -20633,  7000,  3400,  2050,  1350,   930,   650,   460,
                             330,   240,   170,   120,    88,    60,    45,    32 };

  always #5 clk = ~clk;

  fir_hp_mac_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .coef_addr  (coef_addr),
    .coef       (coef),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy)
  );

  fir_hp_coef_rom u_rom (
    .addr (coef_addr),
    .data (coef)
  );

  task automatic model_reset();
    for (int i = 0; i < 32; i++) tb_line[i] = 0;
    tb_wr = 0;
    exp_q.delete();
  endtask

  // Golden model: store the accepted sample, convolve with h, round half up, clamp.
  task automatic model_accept(input logic [15:0] s);
    longint acc;
    longint r;
    int     base;
    tb_line[tb_wr] = int'($signed(s));
    base  = tb_wr;
    tb_wr = (tb_wr + 1) % 32;
    acc   = 0;
    for (int k = 0; k < 32; k++) begin
      acc += longint'(tb_line[(base - k + 32) % 32]) * longint'(h[k]);
    end
    r = (acc + 64'sd16384) >>> 15;
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
    exp_q.push_back(16'(r));
  endtask

  // Advance to the next falling edge and service the output scoreboard there.
  task automatic step();
    logic [15:0] e;
    @(negedge clk);
    if (rst_n === 1'b1 && dout_valid === 1'b1) begin
      checks++;
      obs_q.push_back(dout);
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_dout_valid dout=%h required=no pulse", dout);
      end else begin
        e = exp_q.pop_front();
        if (dout !== e) begin
          failures++;
          $display("FAIL dout_value got=%h required=%h", dout, e);
        end
      end
    end
  endtask

  // Offer one sample and hold it until it is taken; returns just after the accepting edge.
  task automatic send(input logic [15:0] s);
    int n = 0;
    din       = s;
    din_valid = 1'b1;
    while (din_ready !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (din_ready !== 1'b1) begin
      failures++;
      $display("FAIL send_ready_timeout din_ready=%b required=1", din_ready);
    end else begin
      model_accept(s);
    end
    step();
    din_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    din       = '0;
    din_valid = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) step();
    checks++; if (dout !== 16'h0000) begin failures++; $display("FAIL reset_dout got=%h required=0000", dout); end
    checks++; if (dout_valid !== 1'b0) begin failures++; $display("FAIL reset_dout_valid got=%b required=0", dout_valid); end
    checks++; if (din_ready !== 1'b1) begin failures++; $display("FAIL reset_din_ready got=%b required=1", din_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b required=0", busy); end
    checks++; if (coef_addr !== 5'd0) begin failures++; $display("FAIL reset_coef_addr got=%0d required=0", coef_addr); end
  endtask

  // Impulse of 0.5 followed by 31 zeros: outputs trace h[k]/2 rounded.
  task automatic test_impulse();
    obs_q.delete();
    send(16'h4000);
    for (int i = 0; i < 31; i++) send(16'h0000);
    drain();
    checks++;
    if (obs_q.size() != 32) begin
      failures++;
      $display("FAIL impulse_count got=%0d required=32", obs_q.size());
    end else begin
      checks++; if (obs_q[0] !== 16'hFFF0) begin failures++; $display("FAIL impulse_first got=%h required=fff0", obs_q[0]); end
      checks++; if (obs_q[15] !== 16'h284D) begin failures++; $display("FAIL impulse_16th got=%h required=284d", obs_q[15]); end
      checks++; if (obs_q[16] !== 16'hD7B4) begin failures++; $display("FAIL impulse_17th got=%h required=d7b4", obs_q[16]); end
    end
  endtask

  // Cycle n counts falling edges after the accepting rising edge.
  task automatic test_latency();
    logic       exp_busy;
    logic       exp_ready;
    logic       exp_dv;
    logic [4:0] exp_addr;
    send(16'h1000);
    for (int n = 0; n <= 33; n++) begin
      exp_busy  = (n <= 32);
      exp_ready = (n >= 33);
      exp_dv    = (n == 33);
      exp_addr  = (n <= 31) ? 5'(n) : 5'd0;
      checks++; if (busy !== exp_busy) begin failures++; $display("FAIL latency_busy cycle=%0d got=%b required=%b", n, busy, exp_busy); end
      checks++; if (din_ready !== exp_ready) begin failures++; $display("FAIL latency_ready cycle=%0d got=%b required=%b", n, din_ready, exp_ready); end
      checks++; if (dout_valid !== exp_dv) begin failures++; $display("FAIL latency_dout_valid cycle=%0d got=%b required=%b", n, dout_valid, exp_dv); end
      checks++; if (coef_addr !== exp_addr) begin failures++; $display("FAIL latency_coef_addr cycle=%0d got=%0d required=%0d", n, coef_addr, exp_addr); end
      if (n < 33) step();
    end
    drain();
  endtask

  // din_valid held high with a fresh value every cycle; only IDLE cycles take one.
  task automatic test_back_to_back();
    int prev    = -1;
    int acc_cnt = 0;
    for (int n = 0; n < 140; n++) begin
      din       = 16'($urandom);
      din_valid = 1'b1;
      if (din_ready === 1'b1) begin
        model_accept(din);
        if (prev >= 0) begin
          checks++;
          if (n - prev != 34) begin
            failures++;
            $display("FAIL b2b_spacing got=%0d required=34", n - prev);
          end
        end
        prev = n;
        acc_cnt++;
      end
      step();
    end
    din_valid = 1'b0;
    checks++;
    if (acc_cnt != 5) begin
      failures++;
      $display("FAIL b2b_accept_count got=%0d required=5", acc_cnt);
    end
    drain();
  endtask

  // Full-scale samples signed to match (or oppose) each coefficient drive the clamp.
  task automatic test_saturation();
    logic [15:0] last;
    for (int pass = 0; pass < 2; pass++) begin
      obs_q.delete();
      for (int j = 0; j < 32; j++) begin
        if ((h[31 - j] > 0) == (pass == 0)) send(16'h7FFF);
        else send(16'h8000);
      end
      drain();
      last = (obs_q.size() != 0) ? obs_q[obs_q.size() - 1] : 16'hXXXX;
      checks++;
      if (pass == 0 && last !== 16'h7FFF) begin
        failures++;
        $display("FAIL sat_positive got=%h required=7fff", last);
      end else if (pass == 1 && last !== 16'h8000) begin
        failures++;
        $display("FAIL sat_negative got=%h required=8000", last);
      end
    end
  endtask

  // Reset at k=10 discards the accumulation and re-zeroes the history.
  task automatic test_reset_mid_mac();
    send(16'h5A5A);
    repeat (10) step();
    checks++;
    if (coef_addr !== 5'd10) begin
      failures++;
      $display("FAIL midrst_coef_addr got=%0d required=10", coef_addr);
    end
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 40; n++) begin
      step();
      checks++;
      if (dout_valid !== 1'b0) begin
        failures++;
        $display("FAIL midrst_dout_valid cycle=%0d got=%b required=0", n, dout_valid);
      end
    end
    checks++;
    if (dout !== 16'h0000) begin
      failures++;
      $display("FAIL midrst_dout got=%h required=0000", dout);
    end
    test_impulse();
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_latency();
    test_back_to_back();
    test_saturation();
    test_reset_mid_mac();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
